// File: rtl/vector_gather_pkg.sv
// Shared definitions for the vector gather packer and the adder tree it feeds:
// FSM state encoding, count width and lane slice offsets.
package vector_gather_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Width needed to represent 0..n populated lanes.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Bit offset of a lane inside a flat vector word.
    function automatic int lane_base(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/vector_gather.sv
// Serial-to-parallel packer: gathers up to vector_length elements into one
// flat word for the adder tree, zero-padding vectors cut short by in_last.
module vector_gather
    import vector_gather_pkg::*;
#(
    parameter int vector_length = 7,
    parameter int data_width    = 48
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [data_width-1:0]                      in_data,
    input  logic                                       in_valid,
    input  logic                                       in_last,
    output logic                                       in_ready,
    output logic [vector_length*data_width-1:0]        vector_out,
    output logic [count_width(vector_length)-1:0]      vector_count,
    output logic                                       vector_last,
    output logic                                       vector_valid,
    input  logic                                       vector_ready
);

    localparam int count_bits = count_width(vector_length);
    localparam int index_bits = (vector_length > 1) ? $clog2(vector_length) : 1;
    localparam logic [index_bits-1:0] last_index = index_bits'(vector_length - 1);

    localparam logic [0:0] FILL = 1'(ST_FILL);
    localparam logic [0:0] HOLD = 1'(ST_HOLD);

    logic [0:0]            state;
    logic [index_bits-1:0] index;
    logic [index_bits-1:0] eff_index;
    logic [count_bits-1:0] count;
    logic [count_bits-1:0] eff_count;
    logic                  last_q;
    logic                  accept;
    logic                  transfer;
    logic                  closes;
    logic [data_width-1:0] lane_q [vector_length];

    // Valid/ready: a beat moves only in a cycle where both valid and ready are
    // high; the producer holds its payload stable until that cycle. The packer
    // is ready while filling, and while holding only if the held vector leaves
    // in the same cycle, so streaming runs without a bubble.
    assign in_ready     = (state == FILL) || vector_ready;
    assign vector_valid = (state == HOLD);
    assign accept       = in_valid && in_ready;
    assign transfer     = vector_valid && vector_ready;

    // A transfer retires the held vector, so an element accepted alongside it
    // starts a fresh vector at lane 0.
    assign eff_index = transfer ? '0 : index;
    assign eff_count = transfer ? '0 : count;
    assign closes    = in_last || (eff_index == last_index);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= FILL;
            index  <= '0;
            count  <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            state  <= closes ? HOLD : FILL;
            index  <= (eff_index == last_index) ? eff_index : eff_index + index_bits'(1);
            count  <= eff_count + count_bits'(1);
            last_q <= in_last;
        end else if (transfer) begin
            state  <= FILL;
            index  <= '0;
            count  <= '0;
            last_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < vector_length; i++) begin : g_lane
        localparam logic [index_bits-1:0] lane_id = index_bits'(i);
        logic lane_we;

        assign lane_we = accept && (eff_index == lane_id);

        // Clearing on transfer keeps unpopulated lanes at zero for the next vector.
        always_ff @(posedge clk) begin
            if (!reset) begin
                lane_q[i] <= '0;
            end else if (lane_we) begin
                lane_q[i] <= in_data;
            end else if (transfer) begin
                lane_q[i] <= '0;
            end
        end

        assign vector_out[lane_base(i, data_width) +: data_width] = lane_q[i];
    end

    assign vector_count = count;
    assign vector_last  = last_q;

endmodule
